dac_playback: RTL and testbench

Plays back a buffer of ten 12-bit samples to an SPI DAC, such as the MCP4921 on a MIKROE DAC board. It is the transmit-side counterpart of the ADC capture path. A start pulse snapshots the 120-bit sample buffer in the same packed format the ADC capture block produces. The block then sends one 16-bit write frame per sample, oldest sample first, at the same 100 kHz serial clock rate.

---
 rtl/dac_playback.sv | 126 ++++++++++++
 tb/tb_dac_playback.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_playback.sv
// Plays a captured buffer of NUM_SAMPLES 12-bit samples to an SPI DAC (MCP4921 write frames).
// Define DAC_LOOP_EN to keep replaying the captured buffer until stop is seen at a frame gap.
module dac_playback #(
    parameter int CLK_DIV     = 250,
    parameter int NUM_SAMPLES = 10,
    parameter int SAMPLE_W    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    input  logic [NUM_SAMPLES*SAMPLE_W-1:0] storage,
    output logic                            CS,
    output logic                            SCK,
    output logic                            MOSI,
    output logic                            busy,
    output logic                            done,
    output logic [3:0]                      idx
);
    localparam int BUF_W = NUM_SAMPLES * SAMPLE_W;
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [5:0]           ph;
    logic [14:0]          sr;
    logic [BUF_W-1:0]     buffer;
    logic [SAMPLE_W-1:0]  samp [NUM_SAMPLES];
    logic [15:0]          first_word, next_word;
    logic [5:0]           t_nxt;
    logic [3:0]           nxt_idx;
    logic                 tick, last, finish;

    for (genvar i = 0; i < NUM_SAMPLES; i++) begin : g_samp
        assign samp[i] = buffer[(NUM_SAMPLES-1-i)*SAMPLE_W +: SAMPLE_W];
    end

    assign tick       = (cnt == CNT_W'(CLK_DIV - 1));
    assign t_nxt      = ph + 6'd1;
    assign last       = (idx == 4'(NUM_SAMPLES - 1));
    assign first_word = {4'b0011, storage[BUF_W-1 -: SAMPLE_W]};
    assign next_word  = {4'b0011, samp[nxt_idx]};

`ifdef DAC_LOOP_EN
    assign nxt_idx = last ? 4'd0 : idx + 4'd1;
    assign finish  = stop;
`else
    assign nxt_idx = idx + 4'd1;
    assign finish  = stop || last;
`endif

    // ph holds the tick number within the frame; every event fires on the tick that reaches t_nxt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ph     <= '0;
            sr     <= '0;
            buffer <= '0;
            CS     <= 1'b1;
            SCK    <= 1'b0;
            MOSI   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        buffer <= storage;
                        idx    <= '0;
                        cnt    <= '0;
                        ph     <= '0;
                        sr     <= first_word[14:0];
                        MOSI   <= first_word[15];
                        CS     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        ph <= t_nxt;
                        if (t_nxt <= 6'd32) begin
                            if (t_nxt[0]) begin
                                SCK <= 1'b1;
                            end else begin
                                SCK  <= 1'b0;
                                MOSI <= sr[14];
                                sr   <= {sr[13:0], 1'b0};
                            end
                        end
                        if (t_nxt == 6'd1)
                            state <= SHIFT;
                        if (t_nxt == 6'd33) begin
                            CS    <= 1'b1;
                            state <= GAP;
                        end
                        if (t_nxt == 6'd36) begin
                            if (finish) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                idx   <= nxt_idx;
                                sr    <= next_word[14:0];
                                MOSI  <= next_word[15];
                                CS    <= 1'b0;
                                ph    <= '0;
                                state <= LOAD;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_playback.sv
// Randomized scoreboard bench for dac_playback at CLK_DIV=4: frames decoded off the SPI pins are
// compared against words and done times predicted from the sample buffer.
module tb_dac_playback;
    localparam int D = 4;
    localparam int N = 10;
    localparam int W = 12;
    localparam int FRAME = 36 * D;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [N*W-1:0] storage = '0;
    logic           cs, sck, mosi, busy, done;
    logic [3:0]     idx;

    dac_playback #(.CLK_DIV(D), .NUM_SAMPLES(N), .SAMPLE_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .storage(storage),
        .CS(cs), .SCK(sck), .MOSI(mosi), .busy(busy), .done(done), .idx(idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int start_cyc = 0;
    int frames_seen = 0;
    int dones_seen = 0;

    logic [15:0] exp_word[$];
    int          exp_idx[$];
    int          exp_done[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name, input longint act);
        checks++;
        $display("FAIL %s: got %0h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // Reference: frame k plays sample k mod N, oldest sample sitting in the top bits of storage
    task automatic push_run(input logic [N*W-1:0] st, input int nframes);
        logic [W-1:0] smp;
        int s;
        for (int k = 0; k < nframes; k++) begin
            s   = k % N;
            smp = W'(st >> (W * (N - 1 - s)));
            exp_word.push_back(16'h3000 | 16'(smp));
            exp_idx.push_back(s);
        end
        exp_done.push_back(nframes * FRAME);
    endtask

    function automatic logic [N*W-1:0] rand_buf();
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = W'($urandom_range(0, 4095));
        return b;
    endfunction

    // Monitor: decodes SPI frames and checks them, plus done timing, against the queues
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [15:0] sh = '0;
    int          rises = 0, cs_low = 0, mosi_age = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs  = 1'b1;
            prev_sck = 1'b0;
            prev_mosi = mosi;
            rises    = 0;
            cs_low   = 0;
            mosi_age = 0;
        end else begin
            if (prev_cs && !cs) begin
                rises  = 0;
                cs_low = 0;
                sh     = '0;
            end
            if (!cs) cs_low++;
            if (mosi != prev_mosi) mosi_age = 0;
            else mosi_age++;
            if (sck && !prev_sck) begin
                rises++;
                sh = {sh[14:0], mosi};
                check("mosi_setup", mosi_age >= D, 1);
                check("sck_rise_cs", cs, 0);
            end
            if (!prev_cs && cs) begin
                frames_seen++;
                if (exp_word.size() == 0) fail("extra_frame", sh);
                else begin
                    check("frame_word", sh, exp_word.pop_front());
                    check("frame_idx", idx, exp_idx.pop_front());
                    check("frame_rises", rises, 16);
                    check("cs_low_clks", cs_low, 33 * D);
                end
            end
            if (done) begin
                dones_seen++;
                if (exp_done.size() == 0) fail("extra_done", cyc - start_cyc);
                else check("done_time", cyc - start_cyc, exp_done.pop_front());
                check("busy_at_done", busy, 0);
            end
            prev_cs   = cs;
            prev_sck  = sck;
            prev_mosi = mosi;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("busy_after_start", busy, 1);
        check("cs_after_start", cs, 0);
    endtask

    task automatic wait_done(input int limit);
        int d0 = dones_seen;
        for (int i = 0; i < limit && dones_seen == d0; i++) begin
            @(negedge clk);
            #1;
        end
        if (dones_seen == d0) fail("done_timeout", cyc);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idx(input int v, input int limit);
        int i = 0;
        while (!(idx == 4'(v) && !cs) && i < limit) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (i >= limit) fail("idx_timeout", idx);
    endtask

    task automatic check_reset_vals();
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", idx, 0);
    endtask

    task automatic stopped_run(input int stop_at);
        logic [N*W-1:0] st = rand_buf();
        storage = st;
        push_run(st, stop_at + 1);
        do_start();
        wait_idx(stop_at, (stop_at + 1) * FRAME + 20);
        stop = 1'b1;
        wait_done(2 * FRAME);
        stop = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] st;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifndef DAC_LOOP_EN
        // full pass with samples 1..10; storage scrambled right after start
        for (int k = 0; k < N; k++) st[(N-1-k)*W +: W] = W'(k + 1);
        storage = st;
        push_run(st, N);
        do_start();
        storage = rand_buf();
        wait_done(N * FRAME + 50);

        // random buffer with a second start while busy, which must be ignored
        st = rand_buf();
        storage = st;
        push_run(st, N);
        do_start();
        repeat ($urandom_range(50, 3 * FRAME)) @(negedge clk);
        storage = rand_buf();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(N * FRAME + 50);

        // start and stop together from idle: exactly one frame
        st = rand_buf();
        storage = st;
        stop = 1'b1;
        push_run(st, 1);
        do_start();
        wait_done(2 * FRAME);
        stop = 1'b0;
`else
        // looping build: 25 frames wrap through the buffer, then stop in the gap
        begin
            int f0 = frames_seen;
            int i = 0;
            st = rand_buf();
            storage = st;
            push_run(st, 25);
            do_start();
            while (frames_seen < f0 + 25 && i < 26 * FRAME) begin
                @(negedge clk);
                #1;
                i++;
            end
            if (frames_seen < f0 + 25) fail("loop_timeout", frames_seen - f0);
            stop = 1'b1;
            wait_done(2 * FRAME);
            stop = 1'b0;
        end
`endif

        stopped_run(3);
        stopped_run($urandom_range(0, N - 2));

        // reset in frame 2 around tick 10, then a fresh run from idx 0
        st = rand_buf();
        storage = st;
        push_run(st, N);
        do_start();
        wait_idx(2, 3 * FRAME + 20);
        repeat (10 * D) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        exp_word.delete();
        exp_idx.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        stopped_run(2);

        repeat (5) @(negedge clk);
        check("frames_left", exp_word.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        fail("global_timeout", cyc);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
